// File: rtl/ogr_host_link_pkg.sv
// Shared definitions for the OGR host link: default geometry, FSM encodings, mark packing.
// The frame-checksum feature is selected by the OGR_FRAME_CHECKSUM_EN macro in ogr_host_link.
package ogr_host_link_pkg;

  localparam int unsigned DefNumMarks = 6;
  localparam int unsigned DefMarkW    = 9;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  // Position within the output frame while draining.
  localparam logic [1:0] PhHeader = 2'd0;
  localparam logic [1:0] PhData   = 2'd1;
  localparam logic [1:0] PhCsum   = 2'd2;

  // LSB of mark k in a packed ruler; m[0] sits in the MSBs.
  function automatic int unsigned mark_lo(int unsigned k, int unsigned num_marks,
                                          int unsigned mark_w);
    return (num_marks - 1 - k) * mark_w;
  endfunction

endpackage

// File: rtl/ogr_result_fifo.sv
// Circular result buffer for the OGR host link; pointers wrap modulo Depth and an
// occupancy counter drives full/empty.
module ogr_result_fifo #(
  parameter int unsigned Width = 54,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CountW = $clog2(Depth + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [Width-1:0]  push_data,
  input  logic              pop,
  output logic [Width-1:0]  pop_data,
  output logic              full,
  output logic              empty,
  output logic [CountW-1:0] count
);

  logic [Width-1:0]  mem [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign full     = (count_q == CountW'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ogr_host_link.sv
// Host-side companion to the Golomb ruler search: seed load, run control, result buffering
// and framed dump. Define OGR_FRAME_CHECKSUM_EN to append an XOR checksum word to each frame.
module ogr_host_link
  import ogr_host_link_pkg::*;
#(
  parameter int unsigned NUM_MARKS    = DefNumMarks,
  parameter int unsigned MARK_W       = DefMarkW,
  parameter int unsigned RESULT_DEPTH = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [MARK_W-1:0]           cmd_data,
  output logic [NUM_MARKS*MARK_W-1:0] firstvalues,
  output logic                        search_reset,
  input  logic [NUM_MARKS*MARK_W-1:0] ruler_marks,
  input  logic                        ruler_found,
  input  logic                        search_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MARK_W-1:0]           out_data,
  output logic                        out_last,
  output logic [CNT_W-1:0]            num_results_observed,
  output logic                        overflow,
  output logic                        busy
);

  localparam int unsigned FvW    = NUM_MARKS * MARK_W;
  localparam int unsigned IdxW   = (NUM_MARKS > 1) ? $clog2(NUM_MARKS) : 1;
  localparam int unsigned CountW = $clog2(RESULT_DEPTH + 1);

`ifdef OGR_FRAME_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  if (RESULT_DEPTH >= (2 ** MARK_W)) begin : gen_depth_check
    $error("RESULT_DEPTH must be below 2**MARK_W so the header count fits in one word");
  end

  logic [1:0]        state_q, state_d, phase_q, phase_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [MARK_W-1:0] csum_q, csum_d;
  logic [CNT_W-1:0]  obs_q, obs_d;
  logic              ovf_q, ovf_d;
  logic [MARK_W-1:0] fv_q [NUM_MARKS];
  logic [MARK_W-1:0] fv_d [NUM_MARKS];
  logic [MARK_W-1:0] res_marks [NUM_MARKS];

  logic              push, pop, fifo_full, fifo_empty;
  logic [CountW-1:0] fifo_count;
  logic [FvW-1:0]    fifo_rdata;
  logic              idx_last, one_left, last;
  logic [MARK_W-1:0] word;

  ogr_result_fifo #(
    .Width (FvW),
    .Depth (RESULT_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (ruler_marks),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  for (genvar g = 0; g < NUM_MARKS; g++) begin : gen_marks
    assign firstvalues[mark_lo(g, NUM_MARKS, MARK_W) +: MARK_W] = fv_q[g];
    assign res_marks[g] = fifo_rdata[mark_lo(g, NUM_MARKS, MARK_W) +: MARK_W];
  end

  assign idx_last = (idx_q == IdxW'(NUM_MARKS - 1));
  assign one_left = (fifo_count == CountW'(1));
  assign push     = (state_q == StRun) && ruler_found && !fifo_full;
  // The head result is retired once its final mark is handed to the host.
  assign pop      = (state_q == StDrain) && out_ready && (phase_q == PhData) && idx_last;

  assign cmd_ready            = (state_q == StLoad);
  assign search_reset         = (state_q != StRun);
  assign busy                 = (state_q != StIdle);
  assign out_valid            = (state_q == StDrain);
  assign out_data             = word;
  assign out_last             = last;
  assign num_results_observed = obs_q;
  assign overflow             = ovf_q;

  always_comb begin
    word = '0;
    last = 1'b0;
    if (state_q == StDrain) begin
      unique case (phase_q)
        PhHeader: begin
          word = MARK_W'(fifo_count);
          last = fifo_empty & ~CsumEn;
        end
        PhData: begin
          word = res_marks[idx_q];
          last = idx_last & one_left & ~CsumEn;
        end
        default: begin
          word = csum_q;
          last = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    obs_d   = obs_q;
    ovf_d   = ovf_q;
    fv_d    = fv_q;
    unique case (state_q)
      StIdle: begin
        state_d = StLoad;
        idx_d   = '0;
        obs_d   = '0;
        ovf_d   = 1'b0;
      end
      StLoad: begin
        if (cmd_valid) begin
          fv_d[idx_q] = cmd_data;
          if (idx_last) begin
            idx_d   = '0;
            state_d = StRun;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (ruler_found) begin
          if (obs_q != '1) obs_d = obs_q + 1'b1;
          if (fifo_full) ovf_d = 1'b1;
        end
        if (search_done) begin
          state_d = StDrain;
          phase_d = PhHeader;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      StDrain: begin
        if (out_ready) begin
          csum_d = csum_q ^ word;
          if (last) begin
            state_d = StIdle;
            phase_d = PhHeader;
            idx_d   = '0;
          end else begin
            unique case (phase_q)
              PhHeader: phase_d = fifo_empty ? PhCsum : PhData;
              PhData: begin
                if (idx_last) begin
                  idx_d = '0;
                  if (one_left) phase_d = PhCsum;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= PhHeader;
      idx_q   <= '0;
      csum_q  <= '0;
      obs_q   <= '0;
      ovf_q   <= 1'b0;
      fv_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      obs_q   <= obs_d;
      ovf_q   <= ovf_d;
      fv_q    <= fv_d;
    end
  end

endmodule

// File: tb/tb_ogr_host_link.sv
// Directed bench for ogr_host_link with default geometry (6 marks, 9-bit, depth 8).
module tb_ogr_host_link;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_data = '0;
  logic [53:0] firstvalues;
  logic        search_reset;
  logic [53:0] ruler_marks = '0;
  logic        ruler_found = 1'b0;
  logic        search_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_data;
  logic        out_last;
  logic [7:0]  num_results_observed;
  logic        overflow;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int stall_bad;
  bit timed_out;
  logic [8:0] got_w[$];
  logic [8:0] exp_w[$];

  ogr_host_link dut (
    .clock                (clock),
    .reset                (reset),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_data             (cmd_data),
    .firstvalues          (firstvalues),
    .search_reset         (search_reset),
    .ruler_marks          (ruler_marks),
    .ruler_found          (ruler_found),
    .search_done          (search_done),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_last             (out_last),
    .num_results_observed (num_results_observed),
    .overflow             (overflow),
    .busy                 (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [53:0] pk(input int a, input int b, input int c, input int d,
                                     input int e, input int f);
    return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f)};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic load_one(input logic [8:0] v);
    bit acc = 0;
    cmd_data  = v;
    cmd_valid = 1'b1;
    for (int w = 0; w < 20 && !acc; w++) begin
      acc = cmd_ready;
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL load_timeout: cmd_ready never seen for seed %0d", v);
    end
  endtask

  task automatic load_seeds();
    for (int i = 0; i < 6; i++) load_one(9'(i));
  endtask

  task automatic strobe(input logic [53:0] r);
    ruler_marks = r;
    ruler_found = 1'b1;
    @(posedge clock); #1;
    ruler_found = 1'b0;
  endtask

  task automatic finish_search();
    search_done = 1'b1;
    @(posedge clock); #1;
    search_done = 1'b0;
  endtask

  task automatic add_exp(input logic [53:0] r);
    for (int j = 0; j < 6; j++) exp_w.push_back(9'(r >> (9 * (5 - j))));
  endtask

  task automatic add_csum();
`ifdef OGR_FRAME_CHECKSUM_EN
    logic [8:0] x = '0;
    foreach (exp_w[i]) x ^= exp_w[i];
    exp_w.push_back(x);
`endif
  endtask

  // Gathers one frame; with stall set, out_ready drops at random and any change of the
  // presented word during a stall is tallied in stall_bad.
  task automatic collect(input bit stall);
    logic [8:0] pw = '0;
    logic       pl = 1'b0;
    bit hp = 0, fin = 0;
    got_w.delete();
    stall_bad = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clock);
      if (hp && (out_valid !== 1'b1 || out_data !== pw || out_last !== pl)) stall_bad++;
      hp = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          got_w.push_back(out_data);
          fin = out_last;
        end else begin
          hp = 1; pw = out_data; pl = out_last;
        end
      end
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    timed_out = !fin;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset cmd_ready: got %b want 0", cmd_ready); end
    tests++; if (search_reset !== 1'b1) begin fails++; $display("FAIL reset search_reset: got %b want 1", search_reset); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    tests++; if (firstvalues !== '0) begin fails++; $display("FAIL reset firstvalues: got %h want 0", firstvalues); end
    tests++; if (out_data !== '0 || out_last !== 1'b0) begin fails++; $display("FAIL reset out_data/last: got %0d/%b want 0/0", out_data, out_last); end
    tests++; if (num_results_observed !== '0 || overflow !== 1'b0) begin fails++; $display("FAIL reset counters: got %0d/%b want 0/0", num_results_observed, overflow); end
  endtask

  task automatic test_load();
    ruler_marks = pk(1, 2, 3, 4, 5, 6);
    ruler_found = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    ruler_found = 1'b0;
    for (int i = 0; i < 5; i++) load_one(9'(i));
    tests++; if (search_reset !== 1'b1 || cmd_ready !== 1'b1) begin fails++; $display("FAIL load_mid: got search_reset=%b cmd_ready=%b want 1/1", search_reset, cmd_ready); end
    load_one(9'd5);
    tests++; if (firstvalues !== pk(0, 1, 2, 3, 4, 5)) begin fails++; $display("FAIL load firstvalues: got %h want %h", firstvalues, pk(0, 1, 2, 3, 4, 5)); end
    tests++; if (search_reset !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL load_run: got search_reset=%b cmd_ready=%b busy=%b want 0/0/1", search_reset, cmd_ready, busy); end
    tests++; if (num_results_observed !== 8'd0) begin fails++; $display("FAIL load ignored_strobe: got %0d want 0", num_results_observed); end
  endtask

  task automatic test_two_results();
    strobe(pk(0, 1, 4, 10, 12, 17));
    strobe(pk(0, 1, 4, 10, 15, 17));
    tests++; if (num_results_observed !== 8'd2 || overflow !== 1'b0) begin fails++; $display("FAIL two count: got %0d/%b want 2/0", num_results_observed, overflow); end
    finish_search();
    tests++; if (out_valid !== 1'b1 || out_data !== 9'd2 || search_reset !== 1'b1) begin fails++; $display("FAIL two first_drain: got valid=%b data=%0d srst=%b want 1/2/1", out_valid, out_data, search_reset); end
    exp_w.delete();
    exp_w.push_back(9'd2);
    add_exp(pk(0, 1, 4, 10, 12, 17));
    add_exp(pk(0, 1, 4, 10, 15, 17));
    add_csum();
    collect(1'b0);
    tests++; if (timed_out || got_w.size() != exp_w.size()) begin fails++; $display("FAIL two length: got %0d want %0d", got_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL two word%0d: got %0d want %0d", i, got_w[i], exp_w[i]); end
    end
    tests++; if (out_valid !== 1'b0 || num_results_observed !== 8'd2) begin fails++; $display("FAIL two after: got valid=%b count=%0d want 0/2", out_valid, num_results_observed); end
  endtask

  task automatic test_overflow();
    do_reset();
    load_seeds();
    for (int r = 0; r < 10; r++) strobe(pk(r, r + 1, r + 2, r + 3, r + 4, r + 5));
    tests++; if (num_results_observed !== 8'd10 || overflow !== 1'b1) begin fails++; $display("FAIL ovf count: got %0d/%b want 10/1", num_results_observed, overflow); end
    finish_search();
    exp_w.delete();
    exp_w.push_back(9'd8);
    for (int r = 0; r < 8; r++) add_exp(pk(r, r + 1, r + 2, r + 3, r + 4, r + 5));
    add_csum();
    collect(1'b0);
    tests++; if (timed_out || got_w.size() != exp_w.size()) begin fails++; $display("FAIL ovf length: got %0d want %0d", got_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL ovf word%0d: got %0d want %0d", i, got_w[i], exp_w[i]); end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf sticky: got %b want 1", overflow); end
  endtask

  task automatic test_empty();
    do_reset();
    load_seeds();
    finish_search();
    exp_w.delete();
    exp_w.push_back(9'd0);
    add_csum();
    collect(1'b0);
    tests++; if (timed_out || got_w.size() != exp_w.size()) begin fails++; $display("FAIL empty length: got %0d want %0d", got_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL empty word%0d: got %0d want %0d", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_seeds();
    strobe(pk(0, 2, 7, 13, 21, 30));
    strobe(pk(0, 3, 9, 17, 28, 33));
    strobe(pk(0, 1, 6, 14, 25, 44));
    finish_search();
    exp_w.delete();
    exp_w.push_back(9'd3);
    add_exp(pk(0, 2, 7, 13, 21, 30));
    add_exp(pk(0, 3, 9, 17, 28, 33));
    add_exp(pk(0, 1, 6, 14, 25, 44));
    add_csum();
    collect(1'b1);
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL bp stable: got %0d unstable stall cycles want 0", stall_bad); end
    tests++; if (timed_out || got_w.size() != exp_w.size()) begin fails++; $display("FAIL bp length: got %0d want %0d", got_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL bp word%0d: got %0d want %0d", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    load_seeds();
    strobe(pk(0, 1, 4, 10, 12, 17));
    strobe(pk(0, 1, 4, 10, 15, 17));
    finish_search();
    out_ready = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || search_reset !== 1'b1) begin fails++; $display("FAIL midrst state: got valid=%b busy=%b srst=%b want 0/0/1", out_valid, busy, search_reset); end
    tests++; if (num_results_observed !== 8'd0 || overflow !== 1'b0) begin fails++; $display("FAIL midrst counters: got %0d/%b want 0/0", num_results_observed, overflow); end
    load_seeds();
    strobe(pk(0, 5, 6, 9, 20, 31));
    finish_search();
    exp_w.delete();
    exp_w.push_back(9'd1);
    add_exp(pk(0, 5, 6, 9, 20, 31));
    add_csum();
    collect(1'b0);
    tests++; if (timed_out || got_w.size() != exp_w.size()) begin fails++; $display("FAIL midrst length: got %0d want %0d", got_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL midrst word%0d: got %0d want %0d", i, got_w[i], exp_w[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_two_results();
    test_overflow();
    test_empty();
    test_backpressure();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ogr_host_link.md
Name: ogr_host_link

Overview:
- Parametrised host-side companion to the Golomb ruler search assembly.
- Loads start marks from a host word stream, then runs the search by holding and releasing the search reset.
- Buffers every ruler result the assembly reports in a FIFO, and after search completion streams a framed result dump back to the host.
- Generalises the fixed 6-mark, 5-result collection to NUM_MARKS marks, MARK_W-bit positions and RESULT_DEPTH stored results, with valid/ready flow control in both directions.

Parameters:
NUM_MARKS, 6, marks per ruler including m[0]
MARK_W, 9, bits per mark value
RESULT_DEPTH, 8, results buffered; must be < 2**MARK_W (elaboration error otherwise)
CNT_W, 8, width of observed-result counter (saturating)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  host seed word valid
cmd_ready  out  1  block accepts seed word
cmd_data  in  MARK_W  seed mark, m[0] first
firstvalues  out  NUM_MARKS*MARK_W  seeds to assembly; m[0] in MSBs
search_reset  out  1  reset to assembly
ruler_marks  in  NUM_MARKS*MARK_W  current marks from assembly; same packing as firstvalues
ruler_found  in  1  1-cycle strobe: ruler_marks is a result
search_done  in  1  assembly finished
out_valid  out  1  host output word valid
out_ready  in  1  host accepts word
out_data  out  MARK_W  output word
out_last  out  1  final word of frame
num_results_observed  out  CNT_W  results reported since run start, saturating
overflow  out  1  sticky: a result was dropped because the FIFO was full
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, dominant in any state, mid-run included) gives:
  - state IDLE, FIFO empty, firstvalues=0, search_reset=1;
  - cmd_ready=0, out_valid=0, out_last=0, out_data=0;
  - num_results_observed=0, overflow=0, busy=0.
- States: IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
- IDLE:
  - search_reset=1.
  - Moves to LOAD on the next cycle after reset deasserts.
- LOAD:
  - search_reset=1, cmd_ready=1.
  - Each cmd_valid&cmd_ready beat writes mark index k (k counts 0..NUM_MARKS-1) into firstvalues.
  - After the beat with k=NUM_MARKS-1, goes to RUN.
  - cmd_ready=0 in every other state.
- RUN:
  - search_reset=0 from the first RUN cycle.
  - On ruler_found: push ruler_marks if FIFO not full, else set overflow. num_results_observed increments, saturating at 2**CNT_W-1, in both cases.
  - num_results_observed is visible one cycle after the strobe.
  - search_done moves to DRAIN next cycle. A ruler_found in the same cycle as search_done is still captured.
  - ruler_found outside RUN is ignored.
- DRAIN:
  - search_reset=1 again; first out_valid in the first DRAIN cycle.
  - Frame order: header word = stored count (FIFO occupancy at DRAIN entry), then each stored result oldest first, m[0]..m[NUM_MARKS-1].
  - out_data and out_last are held stable while out_valid & !out_ready. A word advances only on out_valid&out_ready.
  - out_last is on the final word. With zero stored results the header (value 0) carries out_last.
  - After the last handshake: out_valid=0, FIFO empty, next state IDLE.
  - num_results_observed and overflow keep their values until the next reset or LOAD entry, where they clear.
- Throughput: one output word per cycle when out_ready is held high. Frame length = 1 + stored*NUM_MARKS words (+1 with the optional feature).
- FIFO pointers wrap modulo RESULT_DEPTH. full/empty use an extra occupancy counter of width clog2(RESULT_DEPTH+1).

Optional Feature:
OGR_FRAME_CHECKSUM_EN
- Defined: one extra trailing word is appended, the XOR of all preceding frame words (header included). out_last moves to this word. An empty frame is header 0, then checksum 0 with last.
- Undefined: no trailing word. Frame is exactly as above.

Decomposition:
- Shared package/definitions include holds: NUM_MARKS, MARK_W defaults, a mark-packing helper macro (index k -> bit slice, m[0] in MSBs), state encodings IDLE/LOAD/RUN/DRAIN.
- One sub-module: ogr_result_fifo (width NUM_MARKS*MARK_W, depth RESULT_DEPTH, push/pop/full/empty/count).

Test Plan:
- Reset, load seeds 0,1,2,3,4,5 -> firstvalues = {0,1,2,3,4,5}. search_reset falls the cycle after the 6th beat.
- Two ruler_found strobes, marks 0-1-4-10-12-17 then 0-1-4-10-15-17; then search_done; out_ready=1 -> words 2, 0,1,4,10,12,17, 0,1,4,10,15,17. out_last only on the final 17. num_results_observed=2.
- RESULT_DEPTH=8, 10 strobes -> overflow=1, num_results_observed=10, header 8, first 8 results only.
- search_done with no results -> single word 0 with out_last=1. With OGR_FRAME_CHECKSUM_EN: 0 then 0(last).
- Random out_ready backpressure during DRAIN -> out_data/out_last stable while stalled, frame identical to unstalled run. Checksum equals XOR of the frame when enabled.
- Assert reset mid-DRAIN after 3 words -> next cycle out_valid=0, busy=0, counters 0, search_reset=1. A fresh load/run works normally.
